fifo_read_ctrl: RTL
===================

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 3, meaning FIFO depth = 2**ADDR_SIZE words.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flop count of the write-pointer synchronizer, legal range 2..4.
REQ-003 SHALL have parameter AE_THRESH, default 1, meaning almost-empty threshold in words, range 0..2**ADDR_SIZE.
REQ-004 SHALL have port clk_i  input  1  read-domain clock.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port w_ptr_gray_i  input  ADDR_SIZE+1  Gray-coded write pointer from the write clock domain, unsynchronized.
REQ-007 SHALL have port inc_i  input  1  pop request.
REQ-008 SHALL have port ptr_o  output  ADDR_SIZE+1  Gray-coded read pointer, toward the write domain.
REQ-009 SHALL have port addr_o  output  ADDR_SIZE  binary read address to the RAM.
REQ-010 SHALL have port fifo_empty_o  output  1  FIFO empty.
REQ-011 SHALL have port almost_empty_o  output  1  fill level at or below AE_THRESH.
REQ-012 SHALL have port level_o  output  ADDR_SIZE+1  words available to read, range 0..2**ADDR_SIZE.
REQ-013 SHALL have port underflow_o  output  1  one-cycle pulse on a rejected pop.

Function
REQ-014 SHALL pass w_ptr_gray_i through a SYNC_STAGES-deep flop chain clocked by clk_i; only the last stage (wgray_s) SHALL be used by any logic.
REQ-015 SHALL keep a binary read counter rbin of ADDR_SIZE+1 bits, registered; addr_o = rbin[ADDR_SIZE-1:0].
REQ-016 SHALL register ptr_o = (rbin >> 1) ^ rbin, updated on the same edge as rbin, with no combinational path from inc_i.
REQ-017 SHALL define pop = inc_i AND NOT fifo_empty_o; rbin_next = rbin + pop, mod 2**(ADDR_SIZE+1), wrapping silently.
REQ-018 SHALL register fifo_empty_o = (gray(rbin_next) == wgray_s).
REQ-019 SHALL register level_o = (bin(wgray_s) - rbin_next) mod 2**(ADDR_SIZE+1), where bin() is Gray-to-binary conversion.
REQ-020 SHALL register almost_empty_o = (level_next <= AE_THRESH), where level_next is the value loaded into level_o.
REQ-021 SHALL register underflow_o = inc_i AND fifo_empty_o; rbin and ptr_o SHALL be unchanged in that cycle.
REQ-022 SHALL make the write-pointer latency exactly SYNC_STAGES+1 rising edges: w_ptr_gray_i stable before edge 1 is reflected in fifo_empty_o, level_o and almost_empty_o after edge SYNC_STAGES+1.
REQ-023 SHALL, on a pop that consumes the last word, assert fifo_empty_o on the same edge that advances rbin, so no second pop of that word is possible.
REQ-024 SHALL, when a write-pointer update and a pop take effect on the same edge, compute all outputs from both new values.
REQ-025 SHALL report level_o = 2**ADDR_SIZE when the pointers differ only in the MSB (full FIFO), with fifo_empty_o = 0.

Reset
REQ-026 SHALL, while rst_i = 1, immediately and without a clock edge force: rbin = 0, ptr_o = 0, addr_o = 0, all synchronizer flops = 0, fifo_empty_o = 1, level_o = 0, almost_empty_o = 1, underflow_o = 0.
REQ-027 SHALL resume counting from zero on the first rising edge after rst_i deasserts.

Verification (ADDR_SIZE=3, SYNC_STAGES=2, AE_THRESH=1)
REQ-028 SHALL cover reset: rst_i = 1 -> ptr_o = 0000, addr_o = 000, fifo_empty_o = 1, level_o = 0, almost_empty_o = 1, underflow_o = 0.
REQ-029 SHALL cover write visibility: w_ptr_gray_i = 0111 (bin 5), inc_i = 0 -> fifo_empty_o falls and level_o = 5 exactly at edge 3; almost_empty_o = 0.
REQ-030 SHALL cover drain to empty: inc_i = 1 held -> addr_o steps 0..4 and level_o steps 4..0; almost_empty_o rises when level_o = 1; fifo_empty_o = 1 with ptr_o = 0111; the next cycle gives underflow_o = 1 with ptr_o held.
REQ-031 SHALL cover wrap and full: rbin = 0111, w_ptr_gray_i = gray(1111) = 1000 -> level_o = 8, fifo_empty_o = 0; pops take addr_o from 7 to 0 and ptr_o MSB toggles (gray(1000) = 1100).
REQ-032 SHALL cover async reset mid-stream: rst_i pulsed between edges with addr_o = 3 -> all outputs reach reset values before the next edge, and w_ptr_gray_i is ignored for SYNC_STAGES+1 edges after release.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read-side pointer control for an asynchronous FIFO: synchronizes the Gray write
// pointer, advances the read pointer on accepted pops, and derives empty/level flags.
module fifo_read_ctrl #(
  parameter int unsigned ADDR_SIZE   = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE:0]   w_ptr_gray_i,
  input  logic                 inc_i,
  output logic [ADDR_SIZE:0]   ptr_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic                 fifo_empty_o,
  output logic                 almost_empty_o,
  output logic [ADDR_SIZE:0]   level_o,
  output logic                 underflow_o
);

  localparam int unsigned W = ADDR_SIZE + 1;

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int i = 1; i < int'(W); i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]                  wgray_s;
  logic [W-1:0]                  wbin_s;
  logic [W-1:0]                  rbin;
  logic [W-1:0]                  rbin_next_c;
  logic [W-1:0]                  rgray_next_c;
  logic [W-1:0]                  level_next_c;
  logic                          pop_c;
  logic                          empty_next_c;
  logic                          ae_next_c;

  // Write-pointer synchronizer; only the final stage feeds any logic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else if (SYNC_STAGES > 1) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], w_ptr_gray_i};
    end else begin
      sync_q <= w_ptr_gray_i;
    end
  end

  assign wgray_s = sync_q[SYNC_STAGES-1];
  assign wbin_s  = gray2bin(wgray_s);

  // Flags are computed from the post-pop pointer so the last word cannot be popped twice.
  always_comb begin
    pop_c        = inc_i & ~fifo_empty_o;
    rbin_next_c  = rbin + W'(pop_c);
    rgray_next_c = bin2gray(rbin_next_c);
    empty_next_c = (rgray_next_c == wgray_s);
    level_next_c = wbin_s - rbin_next_c;
    ae_next_c    = (level_next_c <= W'(AE_THRESH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rbin           <= '0;
      ptr_o          <= '0;
      fifo_empty_o   <= 1'b1;
      level_o        <= '0;
      almost_empty_o <= 1'b1;
      underflow_o    <= 1'b0;
    end else begin
      rbin           <= rbin_next_c;
      ptr_o          <= rgray_next_c;
      fifo_empty_o   <= empty_next_c;
      level_o        <= level_next_c;
      almost_empty_o <= ae_next_c;
      underflow_o    <= inc_i & fifo_empty_o;
    end
  end

  assign addr_o = rbin[ADDR_SIZE-1:0];

endmodule
